// File: rtl/usb_bus_state_ctrl.sv
// usb_bus_state_ctrl: full-speed USB line-state decoder and bus-state sequencer (reset/suspend/resume/remote wakeup)
package usb_bus_state_pkg;
  typedef enum logic [2:0] {
    ST_ACTIVE       = 3'd0,
    ST_RESET        = 3'd1,
    ST_SUSPENDED    = 3'd2,
    ST_WAKEUP_DRIVE = 3'd3,
    ST_RESUME_HOST  = 3'd4
  } state_e;
endpackage

module usb_bus_state_ctrl
  import usb_bus_state_pkg::*;
#(
  parameter int RESET_CYCLES      = 30000,
  parameter int SUSPEND_CYCLES    = 144000,
  parameter int RESUME_MIN_CYCLES = 96,
  parameter int WAKEUP_CYCLES     = 96000,
  parameter int CNT_W             = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       usb_p_rx,
  input  logic       usb_n_rx,
  input  logic       wakeup_req,
  output logic [1:0] line_state,
  output logic       bus_reset,
  output logic       suspended,
  output logic       resume_pulse,
  output logic       drive_k,
  output logic [2:0] state_o
);
  localparam logic [1:0] LS_SE0 = 2'd0;
  localparam logic [1:0] LS_J   = 2'd1;
  localparam logic [1:0] LS_K   = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RESET_TH   = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] SUSPEND_TH = CNT_W'(SUSPEND_CYCLES);
  localparam logic [CNT_W-1:0] RESUME_TH  = CNT_W'(RESUME_MIN_CYCLES);
  localparam logic [CNT_W-1:0] WAKEUP_TH  = CNT_W'(WAKEUP_CYCLES);
  state_e           state_q, state_d;
  logic [1:0]       line_state_q, line_state_d;
  logic [1:0]       prev_ls_q, prev_ls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc, run_len;
  logic             resume_pulse_q, resume_pulse_d;
  // Registers: line state pipeline, run counter, FSM state and the resume pulse; async reset idles on J in ACTIVE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_state_q   <= LS_J;
      prev_ls_q      <= LS_J;
      cnt_q          <= '0;
      state_q        <= ST_ACTIVE;
      resume_pulse_q <= 1'b0;
    end else begin
      line_state_q   <= line_state_d;
      prev_ls_q      <= prev_ls_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      resume_pulse_q <= resume_pulse_d;
    end
  end
  // Run length of the registered line state (including this cycle) drives every timed transition.
  always_comb begin
    line_state_d   = {usb_n_rx, usb_p_rx};
    prev_ls_d      = line_state_q;
    cnt_inc        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    run_len        = (line_state_q == prev_ls_q) ? cnt_inc : CNT_ONE;
    state_d        = state_q;
    cnt_d          = '0;
    case (state_q)
      ST_ACTIVE: begin
        if (line_state_q == LS_SE0) begin
          cnt_d   = run_len;
          state_d = (run_len > RESET_TH) ? ST_RESET : ST_ACTIVE;
        end else if (line_state_q == LS_J) begin
          cnt_d   = run_len;
          state_d = (run_len >= SUSPEND_TH) ? ST_SUSPENDED : ST_ACTIVE;
        end
      end
      ST_RESET: state_d = (line_state_q != LS_SE0) ? ST_ACTIVE : ST_RESET;
      ST_SUSPENDED: begin
        if (line_state_q == LS_SE0) begin
          cnt_d   = run_len;
          state_d = (run_len > RESET_TH) ? ST_RESET : ST_SUSPENDED;
        end else if (line_state_q == LS_K) begin
          cnt_d   = run_len;
          state_d = (run_len >= RESUME_TH) ? ST_RESUME_HOST : ST_SUSPENDED;
        end else if (line_state_q == LS_J && wakeup_req) begin
          state_d = ST_WAKEUP_DRIVE;
        end
      end
      ST_WAKEUP_DRIVE: begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc >= WAKEUP_TH) ? ST_RESUME_HOST : ST_WAKEUP_DRIVE;
      end
      ST_RESUME_HOST: begin
        if (line_state_q == LS_J) begin
          state_d = ST_ACTIVE;
        end else if (line_state_q == LS_SE0) begin
          cnt_d   = run_len;
          state_d = (run_len > RESET_TH) ? ST_RESET : ST_RESUME_HOST;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
    cnt_d          = (state_d != state_q) ? '0 : cnt_d;
    resume_pulse_d = (state_q == ST_RESUME_HOST) && (state_d == ST_ACTIVE);
  end
  assign line_state   = line_state_q;
  assign bus_reset    = (state_q == ST_RESET);
  assign suspended    = (state_q == ST_SUSPENDED) || (state_q == ST_WAKEUP_DRIVE);
  assign drive_k      = (state_q == ST_WAKEUP_DRIVE);
  assign resume_pulse = resume_pulse_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_usb_bus_state_ctrl.sv
// tb_usb_bus_state_ctrl: directed checks of bus reset, suspend/resume, remote wakeup, async reset and illegal-state recovery
module tb_usb_bus_state_ctrl;
  localparam logic [1:0] SE0 = 2'd0;
  localparam logic [1:0] J   = 2'd1;
  localparam logic [1:0] K   = 2'd2;
  localparam logic [1:0] SE1 = 2'd3;
  logic       clk = 1'b0;
  logic       reset;
  logic       usb_p_rx, usb_n_rx, wakeup_req;
  logic [1:0] line_state;
  logic       bus_reset, suspended, resume_pulse, drive_k;
  logic [2:0] state_o;
  int         passed = 0;
  int         total = 0;

  usb_bus_state_ctrl #(
    .RESET_CYCLES(20),
    .SUSPEND_CYCLES(50),
    .RESUME_MIN_CYCLES(4),
    .WAKEUP_CYCLES(10),
    .CNT_W(18)
  ) dut (
    .clk(clk),
    .reset(reset),
    .usb_p_rx(usb_p_rx),
    .usb_n_rx(usb_n_rx),
    .wakeup_req(wakeup_req),
    .line_state(line_state),
    .bus_reset(bus_reset),
    .suspended(suspended),
    .resume_pulse(resume_pulse),
    .drive_k(drive_k),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] ls);
    {usb_n_rx, usb_p_rx} = ls;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1;
    wakeup_req = 1'b0;
    drive(J);
    cyc(3);
    check("rst_state", state_o, 0);
    check("rst_line_state", line_state, 1);
    check("rst_bus_reset", bus_reset, 0);
    check("rst_suspended", suspended, 0);
    check("rst_resume_pulse", resume_pulse, 0);
    check("rst_drive_k", drive_k, 0);
    reset = 1'b0;
    drive(SE0);
    cyc(21);
    check("se0_21_state", state_o, 0);
    check("se0_21_bus_reset", bus_reset, 0);
    cyc(1);
    check("se0_22_state", state_o, 1);
    check("se0_22_bus_reset", bus_reset, 1);
    check("se0_22_suspended", suspended, 0);
    cyc(8);
    check("se0_30_bus_reset", bus_reset, 1);
    drive(J);
    cyc(1);
    check("j_reg_bus_reset", bus_reset, 1);
    cyc(1);
    check("j_active_state", state_o, 0);
    check("j_active_bus_reset", bus_reset, 0);
    drive(SE0);
    cyc(15);
    check("glitch15_state", state_o, 0);
    check("glitch15_bus_reset", bus_reset, 0);
    drive(SE1);
    cyc(1);
    drive(SE0);
    cyc(15);
    check("se1_break_state", state_o, 0);
    check("se1_break_bus_reset", bus_reset, 0);
    drive(J);
    cyc(50);
    check("j50_state", state_o, 0);
    check("j50_suspended", suspended, 0);
    cyc(1);
    check("susp_state", state_o, 2);
    check("susp_suspended", suspended, 1);
    check("susp_bus_reset", bus_reset, 0);
    drive(K);
    cyc(3);
    drive(J);
    cyc(3);
    check("k3_state", state_o, 2);
    check("k3_suspended", suspended, 1);
    drive(K);
    cyc(4);
    check("k4_state", state_o, 2);
    drive(SE0);
    cyc(1);
    check("resume_state", state_o, 4);
    check("resume_suspended", suspended, 0);
    cyc(1);
    check("resume_se0_pulse", resume_pulse, 0);
    drive(J);
    cyc(1);
    check("resume_jreg_state", state_o, 4);
    check("resume_jreg_pulse", resume_pulse, 0);
    cyc(1);
    check("resume_done_state", state_o, 0);
    check("resume_pulse_hi", resume_pulse, 1);
    cyc(1);
    check("resume_pulse_lo", resume_pulse, 0);
    cyc(48);
    check("re_susp_pre", state_o, 0);
    cyc(1);
    check("re_susp_state", state_o, 2);
    wakeup_req = 1'b1;
    cyc(1);
    check("wake_state", state_o, 3);
    wakeup_req = 1'b0;
    drive(K);
    for (int i = 0; i < 10; i++) begin
      check("wake_drive_k", drive_k, 1);
      check("wake_suspended", suspended, 1);
      cyc(1);
    end
    check("wake_end_drive_k", drive_k, 0);
    check("wake_end_state", state_o, 4);
    check("wake_end_suspended", suspended, 0);
    drive(J);
    cyc(1);
    check("wake_jreg_state", state_o, 4);
    cyc(1);
    check("wake_active_state", state_o, 0);
    check("wake_resume_pulse", resume_pulse, 1);
    cyc(49);
    check("rs_pre_state", state_o, 0);
    cyc(1);
    check("rs_susp_state", state_o, 2);
    drive(SE0);
    cyc(21);
    check("rs_se0_21_state", state_o, 2);
    check("rs_se0_21_suspended", suspended, 1);
    check("rs_se0_21_bus_reset", bus_reset, 0);
    cyc(1);
    check("rs_reset_state", state_o, 1);
    check("rs_reset_bus_reset", bus_reset, 1);
    check("rs_reset_suspended", suspended, 0);
    cyc(3);
    drive(J);
    cyc(1);
    check("rs_jreg_state", state_o, 1);
    cyc(1);
    check("rs_active_state", state_o, 0);
    cyc(49);
    cyc(1);
    check("ar_susp_state", state_o, 2);
    wakeup_req = 1'b1;
    cyc(1);
    check("ar_wake_state", state_o, 3);
    check("ar_wake_drive_k", drive_k, 1);
    wakeup_req = 1'b0;
    cyc(3);
    #3;
    reset = 1'b1;
    #1;
    check("ar_drive_k", drive_k, 0);
    check("ar_state", state_o, 0);
    check("ar_suspended", suspended, 0);
    check("ar_line_state", line_state, 1);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ar_after_state", state_o, 0);
    force dut.state_q = usb_bus_state_pkg::state_e'(3'd6);
    #1;
    release dut.state_q;
    #1;
    check("bad6_state", state_o, 6);
    check("bad6_drive_k", drive_k, 0);
    @(posedge clk);
    #1;
    check("bad6_recover", state_o, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/usb_bus_state_ctrl.md
Name: usb_bus_state_ctrl

Overview:
Full-speed USB bus-state controller sitting between the pad receivers and the protocol engine.
- Decodes the received line state and sequences the device through active, bus-reset, suspend, host-resume and remote-wakeup.
- Produces the bus-reset and suspend indications consumed by the rest of the bootloader.
- Drives K on the bus for remote wakeup when requested.

Parameters:
RESET_CYCLES, 30000, consecutive SE0 cycles required before bus reset is declared (threshold is strictly greater-than).
SUSPEND_CYCLES, 144000, consecutive J (idle) cycles in ACTIVE before entering suspend (3 ms at 48 MHz).
RESUME_MIN_CYCLES, 96, consecutive K cycles in SUSPENDED to recognise host resume.
WAKEUP_CYCLES, 96000, cycles the block drives K for remote wakeup (2 ms at 48 MHz).
CNT_W, 18, width of the single shared line-state counter; must hold the largest cycle parameter + 1.

Ports:
clk  input  1  48 MHz system clock.
reset  input  1  asynchronous, active-high; all state and outputs go to reset values immediately.
usb_p_rx  input  1  D+ receive, already synchronised to clk.
usb_n_rx  input  1  D- receive, already synchronised to clk.
wakeup_req  input  1  level; request remote wakeup; honoured only in SUSPENDED.
line_state  output  2  registered decode: 0=SE0, 1=J (p=1,n=0), 2=K (p=0,n=1), 3=SE1.
bus_reset  output  1  high while in RESET state.
suspended  output  1  high while in SUSPENDED or WAKEUP_DRIVE.
resume_pulse  output  1  one-cycle pulse on the transition RESUME_HOST -> ACTIVE.
drive_k  output  1  high while in WAKEUP_DRIVE; pad logic forces K when set.
state_o  output  3  current FSM state encoding, for debug.

Behaviour:
- Reset values:
  - state = ACTIVE (encoding 0), counter = 0, line_state = 1 (J).
  - bus_reset, suspended, resume_pulse and drive_k = 0.
- line_state is registered from usb_p_rx/usb_n_rx, one cycle latency. All FSM decisions use the registered line_state.
- One counter (CNT_W bits) counts consecutive cycles of the line state relevant to the current state.
  - Cleared whenever the relevant condition breaks, and on every state transition.
  - Saturates at all-ones; never wraps.
- SE1 counts as activity: it breaks every run and is otherwise ignored.
- ACTIVE (0):
  - SE0 run: when the counter > RESET_CYCLES -> RESET.
  - J run: when the counter reaches SUSPEND_CYCLES -> SUSPENDED.
  - A change of line state restarts the count for the new state; K always clears it.
- RESET (1):
  - bus_reset=1 (registered, asserted the cycle after entry).
  - Any non-SE0 line_state -> ACTIVE; bus_reset deasserts that same cycle.
- SUSPENDED (2):
  - suspended=1.
  - SE0 run > RESET_CYCLES -> RESET; suspended drops and bus_reset rises.
  - K run reaching RESUME_MIN_CYCLES -> RESUME_HOST.
  - wakeup_req=1 with line_state J -> WAKEUP_DRIVE.
  - If K and wakeup_req are both present, host resume wins.
- WAKEUP_DRIVE (3):
  - drive_k=1 and suspended=1; received line state is ignored.
  - After exactly WAKEUP_CYCLES cycles with drive_k high -> RESUME_HOST; drive_k deasserts on that transition.
  - wakeup_req is not re-sampled here.
- RESUME_HOST (4):
  - suspended=0. Waits for the host EOP.
  - J -> ACTIVE, with resume_pulse=1 for exactly one cycle.
  - SE0 run > RESET_CYCLES -> RESET.
- Unused encodings 5-7 return to ACTIVE on the next clock.
- Asynchronous reset mid-sequence (e.g. during WAKEUP_DRIVE) drops drive_k immediately, without waiting for a clock.
- Outputs are mutually consistent: bus_reset and suspended are never both high; drive_k implies suspended.

Test Plan:
- Bench parameters for all scenarios: RESET_CYCLES=20, SUSPEND_CYCLES=50, RESUME_MIN_CYCLES=4, WAKEUP_CYCLES=10.
- Bus reset: hold SE0 for 30 cycles then J -> bus_reset rises after 21 counted SE0 cycles (+2 cycles of pipeline), stays high until the cycle J is registered, then state_o=0. An SE0 glitch of 15 cycles produces no bus_reset.
- Suspend/resume: 50 J cycles -> suspended=1. Then 3 K cycles and back to J -> remains suspended. Then 4 K cycles, SE0 2 cycles, J -> suspended falls on entry to RESUME_HOST; a single resume_pulse occurs when J is seen.
- Remote wakeup: in SUSPENDED, assert wakeup_req -> drive_k high for exactly 10 cycles, suspended high throughout; then RESUME_HOST; J -> resume_pulse.
- Reset during suspend: in SUSPENDED, drive SE0 for 25 cycles -> suspended=0 and bus_reset=1 in the same cycle; J returns to ACTIVE.
- Async reset: assert reset mid-WAKEUP_DRIVE between clock edges -> drive_k=0 and state_o=0 before the next clk edge. Separately, force the FSM to state 6 -> ACTIVE one cycle later.
